// File: rtl/yadmc_spram_arb_pkg.sv
// Shared types for the yadmc_spram_arb block.
// Holds the sequencer states, the port identifiers and the round-robin pick rule.
package yadmc_spram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_e;

  // On a tie the port that was not served last wins; otherwise the only requester wins.
  function automatic arb_port_e pick_port(input logic a_req, input logic b_req,
                                          input arb_port_e last);
    if (a_req && b_req) return (last == PORT_A) ? PORT_B : PORT_A;
    if (a_req)          return PORT_A;
    return PORT_B;
  endfunction

endpackage

// File: rtl/yadmc_spram_arb_spram.sv
// Single-port RAM with synchronous read: dout updates only on read cycles.
// Contents are uninitialised; the arbiter's clear sweep gives them a defined value.
module yadmc_spram #(
  parameter int address_depth = 10,
  parameter int data_width    = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [address_depth-1:0] adr_i,
  input  logic [data_width-1:0]    di_i,
  output logic [data_width-1:0]    do_o
);

  localparam int Depth = 1 << address_depth;

  logic [data_width-1:0] mem_q [Depth];
  logic [data_width-1:0] do_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[adr_i] <= di_i;
    else      do_q         <= mem_q[adr_i];
  end

  assign do_o = do_q;

endmodule

// File: rtl/yadmc_spram_arb.sv
// Round-robin two-port sequencer in front of one yadmc_spram, one access per cycle.
// After reset or a clear pulse it sweeps clear_value through every RAM location.
module yadmc_spram_arb
  import yadmc_spram_arb_pkg::*;
#(
  parameter int                    address_depth = 10,
  parameter int                    data_width    = 8,
  parameter logic [data_width-1:0] clear_value   = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  output logic                     clearing_o,

  input  logic                     a_req_i,
  input  logic                     a_we_i,
  input  logic [address_depth-1:0] a_adr_i,
  input  logic [data_width-1:0]    a_di_i,
  output logic                     a_gnt_o,
  output logic                     a_valid_o,
  output logic [data_width-1:0]    a_do_o,

  input  logic                     b_req_i,
  input  logic                     b_we_i,
  input  logic [address_depth-1:0] b_adr_i,
  input  logic [data_width-1:0]    b_di_i,
  output logic                     b_gnt_o,
  output logic                     b_valid_o,
  output logic [data_width-1:0]    b_do_o
);

  arb_state_e               state_q, state_d;
  arb_port_e                last_q, last_d;
  logic [address_depth-1:0] clr_cnt_q, clr_cnt_d;
  logic                     a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic [data_width-1:0]    a_do_q, a_do_d, b_do_q, b_do_d;

  logic                     ram_we;
  logic [address_depth-1:0] ram_adr;
  logic [data_width-1:0]    ram_di;
  logic [data_width-1:0]    ram_do;

  yadmc_spram #(
    .address_depth(address_depth),
    .data_width   (data_width)
  ) u_spram (
    .clk_i(clk_i),
    .we_i (ram_we),
    .adr_i(ram_adr),
    .di_i (ram_di),
    .do_o (ram_do)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    clr_cnt_d = clr_cnt_q;
    a_gnt_o   = 1'b0;
    b_gnt_o   = 1'b0;
    ram_we    = 1'b0;
    ram_adr   = clr_cnt_q;
    ram_di    = clear_value;

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_ARB;
      end
      ST_ARB: begin
        // A clear pulse takes priority and blocks any grant in the same cycle.
        if (clear_i) begin
          clr_cnt_d = '0;
          state_d   = ST_CLEAR;
        end else if (a_req_i || b_req_i) begin
          last_d = pick_port(a_req_i, b_req_i, last_q);
          if (last_d == PORT_A) begin
            a_gnt_o = 1'b1;
            ram_we  = a_we_i;
            ram_adr = a_adr_i;
            ram_di  = a_di_i;
          end else begin
            b_gnt_o = 1'b1;
            ram_we  = b_we_i;
            ram_adr = b_adr_i;
            ram_di  = b_di_i;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign clearing_o = (state_q == ST_CLEAR);

  assign a_rd_d = a_gnt_o && !a_we_i;
  assign b_rd_d = b_gnt_o && !b_we_i;
  assign a_do_d = a_rd_q ? ram_do : a_do_q;
  assign b_do_d = b_rd_q ? ram_do : b_do_q;

  // Read data is shown straight from the RAM in the valid cycle, then held locally.
  assign a_valid_o = a_rd_q;
  assign b_valid_o = b_rd_q;
  assign a_do_o    = a_do_d;
  assign b_do_o    = b_do_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_CLEAR;
      last_q    <= PORT_B;
      clr_cnt_q <= '0;
      a_rd_q    <= 1'b0;
      b_rd_q    <= 1'b0;
      a_do_q    <= '0;
      b_do_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      clr_cnt_q <= clr_cnt_d;
      a_rd_q    <= a_rd_d;
      b_rd_q    <= b_rd_d;
      a_do_q    <= a_do_d;
      b_do_q    <= b_do_d;
    end
  end

endmodule

// File: tb/tb_yadmc_spram_arb.sv
// Randomised bench for yadmc_spram_arb against a cycle-level memory/arbitration model.
module tb_yadmc_spram_arb;

  localparam int        AD = 4;
  localparam int        DW = 8;
  localparam logic [7:0] CV = 8'hA5;
  localparam int        NLOC = 1 << AD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          clearing;
  logic          a_req = 1'b0, a_we = 1'b0, a_gnt, a_valid;
  logic [AD-1:0] a_adr = '0;
  logic [DW-1:0] a_di = '0, a_do;
  logic          b_req = 1'b0, b_we = 1'b0, b_gnt, b_valid;
  logic [AD-1:0] b_adr = '0;
  logic [DW-1:0] b_di = '0, b_do;

  yadmc_spram_arb #(.address_depth(AD), .data_width(DW), .clear_value(CV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .clearing_o(clearing),
    .a_req_i(a_req), .a_we_i(a_we), .a_adr_i(a_adr), .a_di_i(a_di),
    .a_gnt_o(a_gnt), .a_valid_o(a_valid), .a_do_o(a_do),
    .b_req_i(b_req), .b_we_i(b_we), .b_adr_i(b_adr), .b_di_i(b_di),
    .b_gnt_o(b_gnt), .b_valid_o(b_valid), .b_do_o(b_do)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int         sweep_left;
  logic [7:0] mem_m [NLOC];
  bit         last_b;
  bit         pa, pb;
  logic [7:0] pda, pdb, hda, hdb;
  bit         ga, gb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    sweep_left = NLOC;
    last_b = 1'b1;
    pa = 1'b0; pb = 1'b0;
    pda = '0; pdb = '0; hda = '0; hdb = '0;
    ga = 1'b0; gb = 1'b0;
    for (int i = 0; i < NLOC; i++) mem_m[i] = CV;
  endtask

  // Assert reset mid-cycle, verify the immediate output values, release after the next edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_clearing", 32'(clearing), 32'd1);
    check_eq("rst_a_gnt",    32'(a_gnt),    32'd0);
    check_eq("rst_b_gnt",    32'(b_gnt),    32'd0);
    check_eq("rst_a_valid",  32'(a_valid),  32'd0);
    check_eq("rst_b_valid",  32'(b_valid),  32'd0);
    check_eq("rst_a_do",     32'(a_do),     32'd0);
    check_eq("rst_b_do",     32'(b_do),     32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: check outputs for the inputs currently driven, then advance the model.
  task automatic step();
    bit ea, eb;
    #2;
    ea = 1'b0; eb = 1'b0;
    if (sweep_left == 0 && !clear) begin
      if (a_req && b_req) begin
        if (last_b) ea = 1'b1; else eb = 1'b1;
      end else if (a_req) ea = 1'b1;
      else if (b_req)     eb = 1'b1;
    end
    check_eq("clearing", 32'(clearing), 32'(sweep_left > 0));
    check_eq("a_gnt",    32'(a_gnt),    32'(ea));
    check_eq("b_gnt",    32'(b_gnt),    32'(eb));
    check_eq("a_valid",  32'(a_valid),  32'(pa));
    check_eq("b_valid",  32'(b_valid),  32'(pb));
    check_eq("a_do",     32'(a_do),     32'(pa ? pda : hda));
    check_eq("b_do",     32'(b_do),     32'(pb ? pdb : hdb));
    ga = ea; gb = eb;
    @(posedge clk);
    if (pa) hda = pda;
    if (pb) hdb = pdb;
    pa = 1'b0; pb = 1'b0;
    if (sweep_left > 0) begin
      mem_m[NLOC - sweep_left] = CV;
      sweep_left--;
    end else if (clear) begin
      sweep_left = NLOC;
    end else if (ea) begin
      last_b = 1'b0;
      if (a_we) mem_m[a_adr] = a_di;
      else begin pa = 1'b1; pda = mem_m[a_adr]; end
    end else if (eb) begin
      last_b = 1'b1;
      if (b_we) mem_m[b_adr] = b_di;
      else begin pb = 1'b1; pdb = mem_m[b_adr]; end
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; b_req = 1'b0; clear = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset sweep with B holding a read of address 3 from release.
    b_req = 1'b1; b_we = 1'b0; b_adr = 4'd3;
    repeat (NLOC + 2) step();
    idle_inputs();
    step();

    // A writes 5, B reads 5 the next cycle.
    a_req = 1'b1; a_we = 1'b1; a_adr = 4'd5; a_di = 8'h3C;
    step();
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_adr = 4'd5;
    step();
    b_req = 1'b0;
    step();

    // Both ports hold reads: strict alternation.
    a_req = 1'b1; a_we = 1'b0; a_adr = 4'd5;
    b_req = 1'b1; b_we = 1'b0; b_adr = 4'd3;
    repeat (8) step();
    idle_inputs();
    step();

    // B read, then clear the next cycle; sweep, then read back every location.
    b_req = 1'b1; b_we = 1'b0; b_adr = 4'd5;
    step();
    b_req = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (NLOC) step();
    for (int i = 0; i < NLOC; i++) begin
      a_req = 1'b1; a_we = 1'b0; a_adr = AD'(i);
      step();
    end
    idle_inputs();
    step();

    // Reset in the middle of a sweep.
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (7) step();
    do_reset();
    repeat (NLOC + 1) step();

    // Write request held while clear is raised: blocked until the sweep ends.
    a_req = 1'b1; a_we = 1'b1; a_adr = 4'd9; a_di = 8'h77; clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (NLOC + 1) step();
    a_req = 1'b1; a_we = 1'b0; a_adr = 4'd9;
    step();
    idle_inputs();
    step();

    // Randomised traffic with occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      if (a_req && !ga) begin
        if ($urandom_range(0, 9) == 0) a_req = 1'b0;
      end else begin
        a_req = ($urandom_range(0, 2) != 0);
        a_we  = $urandom_range(0, 1) != 0;
        a_adr = AD'($urandom);
        a_di  = DW'($urandom);
      end
      if (b_req && !gb) begin
        if ($urandom_range(0, 9) == 0) b_req = 1'b0;
      end else begin
        b_req = ($urandom_range(0, 2) != 0);
        b_we  = $urandom_range(0, 1) != 0;
        b_adr = AD'($urandom);
        b_di  = DW'($urandom);
      end
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        ga = 1'b0; gb = 1'b0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
